hazard_scoreboard: RTL
======================

# hazard_scoreboard

- Issues stall and flush control to the pipeline front end whenever forwarding cannot resolve a hazard:
  - load-use hazards;
  - dependencies on a pending long-latency result (load miss or divide) held in a per-register scoreboard;
  - control flushes from a taken branch.
- Sits beside the EX/MEM/WB forwarding selectors: forwarding supplies operands that already exist, and this block holds back consumers whose operands do not yet exist.
- Keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- `NREG`, 32: architectural registers; the scoreboard is `NREG` bits, and x0 is never tracked.
- `CNTW`, 32: stall counter width.

Ports:
- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_ID_valid`  in  1  ID holds a real instruction.
- `i_ID_rnum1`, `i_ID_rnum2`  in  `reg_t`  ID source registers.
- `i_ID_ren1`, `i_ID_ren2`  in  1  source actually read.
- `i_ID_wnum`  in  `reg_t`  ID destination.
- `i_ID_wen`  in  1  ID writes its destination.
- `i_ID_long`  in  1  ID instruction goes to the long-latency unit.
- `i_EX_memRead`  in  1  EX holds a load.
- `i_EX_wnum`  in  `reg_t`  EX destination.
- `i_LU_done`  in  1  long unit writes back this cycle.
- `i_LU_wnum`  in  `reg_t`  long unit destination.
- `i_branch_taken`  in  1  EX resolved a taken branch or jump.
- `o_stall_IF`, `o_stall_ID`  out  1  hold PC and IF/ID.
- `o_flush_IFID`, `o_flush_IDEX`  out  1  insert bubble.
- `o_lu_busy`  out  1  long op outstanding.
- `o_stall_cnt`  out  `CNTW`  saturating count of stalled cycles.

## Operation
- State `lu_st`: `LU_IDLE` or `LU_BUSY`; only one long op is outstanding at a time.
  - `LU_IDLE -> LU_BUSY` when a long op issues.
  - `LU_BUSY -> LU_IDLE` on `i_LU_done` with no new issue in the same cycle.
  - On `i_LU_done` with a new issue in the same cycle, stay `LU_BUSY`.
- Scoreboard bit `sb[r]` is set when a long op with `r != 0` and `wen=1` issues, and cleared on `i_LU_done` with `i_LU_wnum == r`.
- Same-cycle clear and set on the same r: the set wins, so the bit stays 1.
- `pend(r) = sb[r] & ~(i_LU_done & i_LU_wnum == r) & r != 0`. A completing result is released the same cycle because WB forwarding supplies it.
- `raw_hz`: `i_ID_valid` and (`ren1 & pend(rnum1)` or `ren2 & pend(rnum2)`).
- `waw_hz`: `i_ID_valid & wen & pend(wnum)`.
- `lu_hz`: `i_ID_valid & i_ID_long & lu_st == LU_BUSY & ~i_LU_done`.
- `lduse_hz`: `i_EX_memRead`, `i_EX_wnum != 0`, and `i_EX_wnum` matches an enabled ID source.
- `stall = (raw_hz | waw_hz | lu_hz | lduse_hz) & ~i_branch_taken`.
  - `o_stall_IF = o_stall_ID = stall`.
  - `o_flush_IDEX = stall | i_branch_taken`.
- `o_flush_IFID = i_branch_taken`.
- Flush beats stall: the ID instruction is killed, so no hazard applies to it.
- Issue is `i_ID_valid & i_ID_long & ~stall & ~i_branch_taken`. A flushed long op never sets the scoreboard or changes state.
- `o_stall_cnt` increments on every cycle with `stall=1` and saturates at all-ones.
- `o_lu_busy = (lu_st == LU_BUSY)`.
- `i_LU_done` while in `LU_IDLE` is a protocol error: ignored, no state change, flagged by a bench assertion.

## Timing
- All stall and flush outputs are combinational from registered state plus current inputs, with zero-cycle latency.
- The scoreboard and `lu_st` update on the rising edge after issue or completion.
- A consumer of a long op stalls from the cycle after issue until, and excluding, the cycle in which `i_LU_done` matches.
- A load-use stall lasts exactly 1 cycle per load.
- Asynchronous reset, including mid-operation:
  - `sb = 0`, `lu_st = LU_IDLE`, `o_stall_cnt = 0`;
  - all outputs are 0 while reset is asserted;
  - a pending long op is forgotten, since the pipeline is reset with it.

## Structure
- Shared package gets:
  - `reg_t` (existing);
  - new enum `lu_state_t {LU_IDLE, LU_BUSY}`;
  - constant `REG_ZERO = '0`.
- Sub-module `STALL_COUNTER` holds the saturating, parameterised-width counter. It is reusable for other performance counters.
- Everything else lives in one always_ff (scoreboard, state, counter enable) plus one always_comb (hazard terms).

## Test plan
- **Load-use.** EX load to x5, ID `add x6,x5,x1` -> stall=1 and flush_IDEX=1 for one cycle, then 0; `o_stall_cnt = 1`.
- **Long op RAW.** Div to x7 issues, then ID reads x7.
  - Stall is held 1 until `i_LU_done`, `i_LU_wnum = 7`; stall=0 in that same cycle.
  - `sb[7]` clears at the next edge.
- **Back-to-back long ops.** Second div issues while `LU_BUSY` -> stall. When done arrives in the same cycle, the second issues; the state stays `LU_BUSY` and the new bit is set.
- **Branch priority.** `i_branch_taken=1` with ID long op to x9 and a RAW hazard present:
  - stall=0, flush_IFID=1, flush_IDEX=1;
  - `sb[9]` stays 0 and the state stays `LU_IDLE`.
- **x0 and reset.**
  - Long op with `wnum = 0` leaves sb at 0, and later reads of x0 are never stalled.
  - `i_rst_n` low mid-`LU_BUSY` -> all outputs 0 immediately.
  - After release, a reader of the previously pending register is not stalled.
- **Counter saturation.** With `CNTW = 4`, 20 stall cycles -> `o_stall_cnt = 15`.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Types and constants shared by the hazard scoreboard and its counter.
//   reg_t       architectural register number (32 registers, 5 bits)
//   lu_state_t  long-latency unit occupancy: LU_IDLE / LU_BUSY
//   REG_ZERO    register x0, which is hard-wired and never tracked
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_t;

  typedef enum logic {
    LU_IDLE = 1'b0,
    LU_BUSY = 1'b1
  } lu_state_t;

  localparam reg_t REG_ZERO = '0;

endpackage

// File: rtl/hazard_scoreboard_stall_counter.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_stall_counter
// Saturating up-counter of parameterised width, usable for any
// performance event.
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset, clears the count
//   i_en     count this cycle
//   o_cnt    current count, sticks at all-ones
// ---------------------------------------------------------------------------
module hazard_scoreboard_stall_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Holds back front-end consumers whose operands do not exist yet:
// load-use hazards, reads/writes of a register owed by the single
// outstanding long-latency op (load miss / divide), a second long op while
// the unit is busy, and kills the ID instruction on a taken branch.
//
// Ports
//   i_clk, i_rst_n                 clock (rising), async active-low reset
//   i_ID_valid                     ID holds a real instruction
//   i_ID_rnum1/2, i_ID_ren1/2      ID sources and their read enables
//   i_ID_wnum, i_ID_wen            ID destination and write enable
//   i_ID_long                      ID instruction uses the long unit
//   i_EX_memRead, i_EX_wnum        EX holds a load to this register
//   i_LU_done, i_LU_wnum           long unit writes back this register
//   i_branch_taken                 EX resolved a taken branch / jump
//   o_stall_IF, o_stall_ID         hold PC and IF/ID
//   o_flush_IFID, o_flush_IDEX     insert bubbles
//   o_lu_busy                      long op outstanding (exposes lu_st)
//   o_stall_cnt                    saturating count of stalled cycles
//
// All stall/flush outputs are combinational from registered state plus the
// current inputs and are forced to 0 while reset is asserted.
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG = 32,
  parameter int CNTW = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ID_valid,
  input  reg_t            i_ID_rnum1,
  input  reg_t            i_ID_rnum2,
  input  logic            i_ID_ren1,
  input  logic            i_ID_ren2,
  input  reg_t            i_ID_wnum,
  input  logic            i_ID_wen,
  input  logic            i_ID_long,
  input  logic            i_EX_memRead,
  input  reg_t            i_EX_wnum,
  input  logic            i_LU_done,
  input  reg_t            i_LU_wnum,
  input  logic            i_branch_taken,
  output logic            o_stall_IF,
  output logic            o_stall_ID,
  output logic            o_flush_IFID,
  output logic            o_flush_IDEX,
  output logic            o_lu_busy,
  output logic [CNTW-1:0] o_stall_cnt
);

  lu_state_t        r_lu_st;
  logic [NREG-1:0]  r_sb;

  lu_state_t        w_lu_st_nxt;
  logic [NREG-1:0]  w_sb_nxt;
  logic             w_lu_done;
  logic             w_pend1;
  logic             w_pend2;
  logic             w_pendw;
  logic             w_raw_hz;
  logic             w_waw_hz;
  logic             w_lu_hz;
  logic             w_lduse_hz;
  logic             w_stall;
  logic             w_issue;

  // State register: scoreboard bits and long-unit occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lu_st <= LU_IDLE;
      r_sb    <= '0;
    end else begin
      r_lu_st <= w_lu_st_nxt;
      r_sb    <= w_sb_nxt;
    end
  end

  // Hazard terms and next state.
  always_comb begin
    w_lu_st_nxt = r_lu_st;
    w_sb_nxt    = r_sb;

    // A completion while idle is a protocol error and is ignored entirely.
    w_lu_done = i_LU_done & (r_lu_st == LU_BUSY);

    // A result completing this cycle is no longer pending: WB forwards it.
    w_pend1 = r_sb[i_ID_rnum1] & ~(w_lu_done & (i_LU_wnum == i_ID_rnum1))
              & (i_ID_rnum1 != REG_ZERO);
    w_pend2 = r_sb[i_ID_rnum2] & ~(w_lu_done & (i_LU_wnum == i_ID_rnum2))
              & (i_ID_rnum2 != REG_ZERO);
    w_pendw = r_sb[i_ID_wnum]  & ~(w_lu_done & (i_LU_wnum == i_ID_wnum))
              & (i_ID_wnum != REG_ZERO);

    w_raw_hz   = i_ID_valid & ((i_ID_ren1 & w_pend1) | (i_ID_ren2 & w_pend2));
    w_waw_hz   = i_ID_valid & i_ID_wen & w_pendw;
    w_lu_hz    = i_ID_valid & i_ID_long & (r_lu_st == LU_BUSY) & ~i_LU_done;
    w_lduse_hz = i_EX_memRead & (i_EX_wnum != REG_ZERO)
                 & ((i_ID_ren1 & (i_ID_rnum1 == i_EX_wnum))
                  | (i_ID_ren2 & (i_ID_rnum2 == i_EX_wnum)));

    // A taken branch kills the ID instruction, so none of its hazards apply.
    w_stall = (w_raw_hz | w_waw_hz | w_lu_hz | w_lduse_hz) & ~i_branch_taken;
    w_issue = i_ID_valid & i_ID_long & ~w_stall & ~i_branch_taken;

    // Clear first, then set, so a same-register clear/set leaves the bit 1.
    if (w_lu_done) begin
      w_sb_nxt[i_LU_wnum] = 1'b0;
    end
    if (w_issue & i_ID_wen & (i_ID_wnum != REG_ZERO)) begin
      w_sb_nxt[i_ID_wnum] = 1'b1;
    end

    if (w_issue) begin
      w_lu_st_nxt = LU_BUSY;
    end else if (w_lu_done) begin
      w_lu_st_nxt = LU_IDLE;
    end
  end

  // Outputs.
  assign o_stall_IF   = w_stall & i_rst_n;
  assign o_stall_ID   = w_stall & i_rst_n;
  assign o_flush_IFID = i_branch_taken & i_rst_n;
  assign o_flush_IDEX = (w_stall | i_branch_taken) & i_rst_n;
  assign o_lu_busy    = (r_lu_st == LU_BUSY);

  hazard_scoreboard_stall_counter #(
    .W (CNTW)
  ) u_stall_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_stall),
    .o_cnt   (o_stall_cnt)
  );

endmodule
